mmu_bus_arbiter: RTL and testbench
==================================

Name: mmu_bus_arbiter

Overview:
- Shares the single MMU bus (ADDR, rdWR, write data, read data) between two masters: the CPU and a DMA engine.
- Sits between both masters and the mmu; only the granted master's address/rdWR/write data reach the bus.
- Policy: fixed priority to the CPU, with a DMA anti-starvation counter and bounded DMA bursts.
- Guarantees no write strobe reaches the bus while no master is granted.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_BURST, 8, maximum consecutive DMA transfers per tenure while dma_lock is high (>=1).
- STARVE_LIMIT, 4, cycles a requesting DMA may be denied before it is forced to win (>=1).

Ports:
- clk  in  1  system clock, same as CPU and mmu
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU requests a bus transfer
- cpu_addr  in  ADDR_W  CPU address
- cpu_rdWR  in  1  CPU direction, 0 read / 1 write
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU owns the bus this cycle
- cpu_ack  out  1  CPU transfer completes this cycle
- cpu_rdata  out  DATA_W  read data to CPU
- dma_req  in  1  DMA requests a bus transfer
- dma_lock  in  1  DMA asks to keep ownership for the next transfer
- dma_addr  in  ADDR_W  DMA address
- dma_rdWR  in  1  DMA direction
- dma_wdata  in  DATA_W  DMA write data
- dma_gnt  out  1  DMA owns the bus this cycle
- dma_ack  out  1  DMA transfer completes this cycle
- dma_rdata  out  DATA_W  read data to DMA
- bus_addr  out  ADDR_W  to mmu ADDR
- bus_rdWR  out  1  to mmu rdWR
- bus_wdata  out  DATA_W  write data onto mmu DATA
- bus_rdata  in  DATA_W  read data from mmu DATA
- owner  out  2  00 idle, 01 CPU, 10 DMA

Behaviour:
- State register: IDLE, CPU, DMA. All transitions occur on the rising clk edge. Grant is registered, so a request arriving in IDLE is granted on the following cycle (1-cycle latency).
- Outputs are combinational from the state:
  - cpu_gnt = (state==CPU); dma_gnt = (state==DMA).
  - owner encodes the state.
  - x_ack = x_gnt & x_req.
  - Bus signals mux the owner's addr/rdWR/wdata.
  - In IDLE: bus_addr = 0, bus_rdWR = 0, bus_wdata = 0.
  - bus_rdata is routed to both cpu_rdata and dma_rdata ungated; masters qualify it with ack.
  - A granted master with req low drives bus_rdWR = 0 (no stray write).
- Arbitration function arb(), evaluated in order:
  1. dma_req & starve==STARVE_LIMIT -> DMA.
  2. cpu_req -> CPU.
  3. dma_req -> DMA.
  4. Otherwise IDLE.
- Per-state next state:
  - IDLE: arb().
  - CPU: if starvation fires -> DMA; else if cpu_req -> CPU; else arb().
  - DMA: stay in DMA if dma_req & dma_lock & burst < MAX_BURST-1; otherwise arb() evaluated with the CPU checked before DMA regardless of starve. DMA re-entering from DMA starts a new tenure.
- starve counter:
  - Increments each cycle dma_req=1 and state!=DMA.
  - Saturates at STARVE_LIMIT.
  - Cleared when state==DMA or when dma_req=0.
- burst counter:
  - Increments on each dma_ack.
  - Cleared on entering DMA from another state or on a new tenure.
  - Saturates at MAX_BURST-1.
- Both requesting in IDLE with starve<STARVE_LIMIT: CPU wins.
- MAX_BURST=1: dma_lock has no effect.
- Reset (any state, mid-transfer):
  - Next cycle state=IDLE, starve=0, burst=0, gnts=0, acks=0, owner=00, bus_rdWR=0.
  - An in-flight transfer is abandoned; the master must re-request.

Optional Feature:
- Macro: MMU_ARB_PARK_CPU_EN.
- Defined:
  - Reset state and no-request state are CPU (bus parked on CPU), so cpu_gnt=1 and owner=01 after reset.
  - A CPU request while parked is acked the same cycle (0 latency).
  - arb() step 4 yields CPU instead of IDLE.
  - Starvation and burst rules are unchanged.
- Undefined: the behaviour above, with IDLE as the rest state.

Test Plan:
1. Reset, then cpu_req=1 (read, addr 0x8000, bus_rdata 0x1234_5678) from cycle 0 -> cpu_gnt from cycle 1, cpu_ack=1, cpu_rdata=0x1234_5678, bus_addr=0x8000.
2. cpu_req and dma_req both high from IDLE, STARVE_LIMIT=4 -> CPU granted cycle 1; starve counts 1..4; DMA granted at cycle 5 (owner=10) while cpu_req still high, cpu_ack=0 that cycle.
3. DMA alone, dma_lock=1, 12 writes to 0xC004, MAX_BURST=8, cpu_req rises in the 3rd DMA cycle -> 8 consecutive dma_acks, then owner=01 for one CPU transfer, then DMA resumes.
4. Idle with cpu_rdWR=1, cpu_req=0 -> bus_rdWR=0, bus_addr=0 every cycle; CPU granted with req dropped -> bus_rdWR=0.
5. rst asserted during DMA burst cycle 3 -> next cycle owner=00, dma_gnt=0, bus_rdWR=0; after release, re-request is granted 1 cycle later with burst restarting at 0.
6. With MMU_ARB_PARK_CPU_EN -> after reset owner=01; cpu_req pulse at cycle 4 gives cpu_ack in cycle 4; dma_req gets the grant 1 cycle later when the CPU is idle.

Source files
------------

// File: rtl/mmu_bus_arbiter.sv
// Two-master (CPU, DMA) arbiter for the shared MMU bus: CPU priority, DMA anti-starvation, bounded DMA bursts.
// Define MMU_ARB_PARK_CPU_EN to park the bus on the CPU instead of idling.
module mmu_bus_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_BURST    = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rdWR,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_lock,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic              dma_rdWR,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_rdWR,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic [1:0]        owner
);

    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CPU  = 2'b01,
        S_DMA  = 2'b10
    } state_t;

`ifdef MMU_ARB_PARK_CPU_EN
    localparam state_t REST = S_CPU;
`else
    localparam state_t REST = S_IDLE;
`endif

    state_t        state;
    state_t        arb_full;
    state_t        arb_cpu_first;
    logic [SW-1:0] starve;
    logic [BW-1:0] burst;
    logic          starve_fire;
    logic          dma_stay;

    // arb_cpu_first is the end-of-burst decision, which ignores starvation so the CPU gets in
    always_comb begin
        starve_fire   = dma_req && (starve == STARVE_MAX);
        dma_stay      = dma_req && dma_lock && (burst < BURST_LAST);
        arb_cpu_first = REST;
        if (cpu_req) begin
            arb_cpu_first = S_CPU;
        end else if (dma_req) begin
            arb_cpu_first = S_DMA;
        end
        arb_full = starve_fire ? S_DMA : arb_cpu_first;
    end

    // burst only counts while a locked tenure continues, so leaving or re-entering DMA restarts it at 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= REST;
            starve <= '0;
            burst  <= '0;
        end else begin
            case (state)
                S_IDLE, S_CPU: begin
                    state <= arb_full;
                    burst <= '0;
                end
                S_DMA: begin
                    if (dma_stay) begin
                        state <= S_DMA;
                        burst <= burst + 1'b1;
                    end else begin
                        state <= arb_cpu_first;
                        burst <= '0;
                    end
                end
                default: begin
                    state <= REST;
                    burst <= '0;
                end
            endcase

            if (state == S_DMA || !dma_req) begin
                starve <= '0;
            end else if (starve != STARVE_MAX) begin
                starve <= starve + 1'b1;
            end
        end
    end

    assign cpu_gnt   = (state == S_CPU);
    assign dma_gnt   = (state == S_DMA);
    assign cpu_ack   = cpu_gnt & cpu_req;
    assign dma_ack   = dma_gnt & dma_req;
    assign owner     = state;
    assign cpu_rdata = bus_rdata;
    assign dma_rdata = bus_rdata;

    // a granted master that has dropped req must not leave a write strobe on the bus
    always_comb begin
        bus_addr  = '0;
        bus_rdWR  = 1'b0;
        bus_wdata = '0;
        if (state == S_CPU) begin
            bus_addr  = cpu_addr;
            bus_rdWR  = cpu_rdWR & cpu_req;
            bus_wdata = cpu_wdata;
        end else if (state == S_DMA) begin
            bus_addr  = dma_addr;
            bus_rdWR  = dma_rdWR & dma_req;
            bus_wdata = dma_wdata;
        end
    end

endmodule

// File: tb/tb_mmu_bus_arbiter.sv
// Scoreboard bench for mmu_bus_arbiter: directed vectors push expected acks, a negedge monitor checks them.
// Define MMU_ARB_PARK_CPU_EN to run the parked-CPU scenario instead of the default ones.
module tb_mmu_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_rdWR, cpu_gnt, cpu_ack;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dma_req, dma_lock, dma_rdWR, dma_gnt, dma_ack;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_rdWR;
    logic [1:0]  owner;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int base;

    typedef struct {
        int          cycle;
        bit          is_dma;
        logic [31:0] addr;
        logic        rw;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } ack_t;

    ack_t sb[$];

    mmu_bus_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_rdWR  (cpu_rdWR),
        .cpu_wdata (cpu_wdata),
        .cpu_gnt   (cpu_gnt),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .dma_req   (dma_req),
        .dma_lock  (dma_lock),
        .dma_addr  (dma_addr),
        .dma_rdWR  (dma_rdWR),
        .dma_wdata (dma_wdata),
        .dma_gnt   (dma_gnt),
        .dma_ack   (dma_ack),
        .dma_rdata (dma_rdata),
        .bus_addr  (bus_addr),
        .bus_rdWR  (bus_rdWR),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .owner     (owner)
    );

    // the mmu returns a fixed word at 0x8000 and the inverted address everywhere else
    assign bus_rdata = (bus_addr == 32'h0000_8000) ? 32'h1234_5678 : ~bus_addr;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic c_req, input logic [31:0] c_addr, input logic c_rw,
                                 input logic [31:0] c_wd, input logic d_req, input logic d_lock,
                                 input logic [31:0] d_addr, input logic d_rw, input logic [31:0] d_wd);
        cpu_req   = c_req;
        cpu_addr  = c_addr;
        cpu_rdWR  = c_rw;
        cpu_wdata = c_wd;
        dma_req   = d_req;
        dma_lock  = d_lock;
        dma_addr  = d_addr;
        dma_rdWR  = d_rw;
        dma_wdata = d_wd;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, actual, expected);
        end
    endtask

    task automatic expectAck(input int c, input bit is_dma, input logic [31:0] a, input logic rw,
                             input logic [31:0] wd, input logic [31:0] rd);
        ack_t e;
        e.cycle  = c;
        e.is_dma = is_dma;
        e.addr   = a;
        e.rw     = rw;
        e.wdata  = wd;
        e.rdata  = rd;
        sb.push_back(e);
    endtask

    // every ack the DUT raises must match the next expected transfer, including the cycle it lands in
    always @(negedge clk) begin
        ack_t        e;
        logic [31:0] rd;
        if (cpu_ack || dma_ack) begin
            vectors++;
            rd = dma_ack ? dma_rdata : cpu_rdata;
            if (sb.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_ack at cycle %0d: cpu_ack=%0b dma_ack=%0b, expected no ack",
                         cyc, cpu_ack, dma_ack);
            end else begin
                e = sb.pop_front();
                if (e.cycle != cyc || cpu_ack == dma_ack || e.is_dma != dma_ack || e.addr !== bus_addr ||
                    e.rw !== bus_rdWR || e.wdata !== bus_wdata || e.rdata !== rd) begin
                    miscompares++;
                    $display("[TB] FAIL ack_check got cyc=%0d dma=%0b cpu=%0b addr=%h rw=%0b wdata=%h rdata=%h, expected cyc=%0d dma=%0b addr=%h rw=%0b wdata=%h rdata=%h",
                             cyc, dma_ack, cpu_ack, bus_addr, bus_rdWR, bus_wdata, rd,
                             e.cycle, e.is_dma, e.addr, e.rw, e.wdata, e.rdata);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
        repeat (2) step();
        @(negedge clk);
`ifdef MMU_ARB_PARK_CPU_EN
        checkOutput("reset_owner", 32'(owner), 32'h1);
        checkOutput("reset_cpu_gnt", 32'(cpu_gnt), 32'h1);
`else
        checkOutput("reset_owner", 32'(owner), 32'h0);
        checkOutput("reset_cpu_gnt", 32'(cpu_gnt), 32'h0);
`endif
        checkOutput("reset_dma_gnt", 32'(dma_gnt), 32'h0);
        checkOutput("reset_bus_rdWR", 32'(bus_rdWR), 32'h0);

`ifdef MMU_ARB_PARK_CPU_EN
        // parked: zero-latency CPU access, DMA one cycle after the CPU goes quiet
        step();
        rst  = 1'b0;
        base = cyc;
        expectAck(base + 4, 0, 32'h8000, 0, 32'h0, 32'h1234_5678);
        expectAck(base + 7, 1, 32'h700, 0, 32'h0, ~32'h700);
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 4) applyStimulus(1, 32'h8000, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
            if (k == 5) cpu_req = 1'b0;
            if (k == 6) applyStimulus(0, 32'h8000, 0, 32'h0, 1, 0, 32'h700, 0, 32'h0);
            if (k == 8) dma_req = 1'b0;
            @(negedge clk);
            if (k == 1) checkOutput("park_owner", 32'(owner), 32'h1);
            if (k == 4) checkOutput("park_cpu_gnt", 32'(cpu_gnt), 32'h1);
            if (k == 7) checkOutput("park_dma_owner", 32'(owner), 32'h2);
            if (k == 9) checkOutput("park_return_owner", 32'(owner), 32'h1);
        end
`else
        step();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_owner", 32'(owner), 32'h0);

        // single CPU read with one cycle grant latency
        step();
        base = cyc;
        applyStimulus(1, 32'h8000, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
        expectAck(base + 1, 0, 32'h8000, 0, 32'h0, 32'h1234_5678);
        @(negedge clk);
        checkOutput("cpu_latency_gnt", 32'(cpu_gnt), 32'h0);
        step();
        @(negedge clk);
        checkOutput("cpu_gnt", 32'(cpu_gnt), 32'h1);
        step();
        cpu_req = 1'b0;
        step();

        // both request: CPU wins four cycles, starvation then forces DMA in
        step();
        base = cyc;
        applyStimulus(1, 32'h100, 0, 32'h0, 1, 0, 32'h200, 0, 32'h0);
        for (int k = 1; k <= 4; k++) expectAck(base + k, 0, 32'h100, 0, 32'h0, ~32'h100);
        expectAck(base + 5, 1, 32'h200, 0, 32'h0, ~32'h200);
        repeat (5) step();
        @(negedge clk);
        checkOutput("starve_owner", 32'(owner), 32'h2);
        checkOutput("starve_cpu_ack", 32'(cpu_ack), 32'h0);
        step();
        applyStimulus(0, 32'h100, 1, 32'hFFFF, 0, 0, 32'h200, 0, 32'h0);
        @(negedge clk);
        checkOutput("nreq_owner", 32'(owner), 32'h1);
        checkOutput("nreq_bus_rdWR", 32'(bus_rdWR), 32'h0);
        checkOutput("nreq_bus_addr", bus_addr, 32'h100);
        for (int k = 0; k < 2; k++) begin
            step();
            @(negedge clk);
            checkOutput("idle_owner2", 32'(owner), 32'h0);
            checkOutput("idle_bus_rdWR", 32'(bus_rdWR), 32'h0);
            checkOutput("idle_bus_addr", bus_addr, 32'h0);
            checkOutput("idle_bus_wdata", bus_wdata, 32'h0);
            checkOutput("idle_dma_rdata", dma_rdata, 32'hFFFF_FFFF);
        end

        // locked DMA burst capped at 8, CPU slips in, DMA finishes 4 more
        step();
        base = cyc;
        applyStimulus(0, 32'h300, 0, 32'h0, 1, 1, 32'hC004, 1, 32'hDA7A_0001);
        for (int k = 1; k <= 8; k++) expectAck(base + k, 1, 32'hC004, 1, 32'hDA7A_0001, ~32'hC004);
        expectAck(base + 9, 0, 32'h300, 0, 32'h0, ~32'h300);
        for (int k = 11; k <= 14; k++) expectAck(base + k, 1, 32'hC004, 1, 32'hDA7A_0001, ~32'hC004);
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 3)  cpu_req = 1'b1;
            if (k == 10) cpu_req = 1'b0;
            if (k == 15) dma_req = 1'b0;
            @(negedge clk);
            if (k == 9)  checkOutput("burst_cpu_owner", 32'(owner), 32'h1);
            if (k == 10) checkOutput("burst_cpu_hold", 32'(owner), 32'h1);
            if (k == 11) checkOutput("burst_resume_owner", 32'(owner), 32'h2);
            if (k == 16) checkOutput("burst_end_owner", 32'(owner), 32'h0);
        end

        // reset in the third DMA cycle, then a fresh 8-long tenure
        step();
        base = cyc;
        applyStimulus(0, 32'h600, 0, 32'h0, 1, 1, 32'h400, 1, 32'h5555_AAAA);
        for (int k = 1; k <= 3; k++) expectAck(base + k, 1, 32'h400, 1, 32'h5555_AAAA, ~32'h400);
        for (int k = 5; k <= 12; k++) expectAck(base + k, 1, 32'h400, 1, 32'h5555_AAAA, ~32'h400);
        expectAck(base + 13, 0, 32'h600, 0, 32'h0, ~32'h600);
        for (int k = 1; k <= 15; k++) begin
            step();
            if (k == 3)  rst = 1'b1;
            if (k == 4)  rst = 1'b0;
            if (k == 6)  cpu_req = 1'b1;
            if (k == 13) dma_req = 1'b0;
            if (k == 14) cpu_req = 1'b0;
            @(negedge clk);
            if (k == 4) begin
                checkOutput("rst_owner", 32'(owner), 32'h0);
                checkOutput("rst_dma_gnt", 32'(dma_gnt), 32'h0);
                checkOutput("rst_bus_rdWR", 32'(bus_rdWR), 32'h0);
            end
            if (k == 5)  checkOutput("rst_regrant", 32'(owner), 32'h2);
            if (k == 12) checkOutput("rst_burst_last", 32'(owner), 32'h2);
            if (k == 13) checkOutput("rst_cpu_after", 32'(owner), 32'h1);
            if (k == 15) checkOutput("rst_end_owner", 32'(owner), 32'h0);
        end
`endif

        repeat (3) step();
        checkOutput("pending_acks", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
